// File: rtl/if_id_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stage_if
// Brief    : Fetch-side inputs and decode-side outputs of the IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
interface if_id_stage_if;
   logic [31:0] Instruction;
   logic [31:0] pc_plus_4;
   logic        ID_EX_MemRead;
   logic [4:0]  ID_EX_RegRt;
   logic        BranchTaken;
   logic [31:0] Instruction_out;
   logic [31:0] pc_plus_4_out;
   logic        Valid_out;
   logic        PCWrite;
   logic        Bubble;
   logic [15:0] StallCount;

   modport master (
      output Instruction, pc_plus_4, ID_EX_MemRead, ID_EX_RegRt, BranchTaken,
      input  Instruction_out, pc_plus_4_out, Valid_out, PCWrite, Bubble, StallCount
   );

   modport slave (
      input  Instruction, pc_plus_4, ID_EX_MemRead, ID_EX_RegRt, BranchTaken,
      output Instruction_out, pc_plus_4_out, Valid_out, PCWrite, Bubble, StallCount
   );
endinterface
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stage
// Brief    : IF/ID pipeline register with load-use stall and branch flush.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_stage (
   input  wire logic   clk,
   input  wire logic   Reset,
   if_id_stage_if.slave bus
);
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

   state_t      state_q, state_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [15:0] cnt_q, cnt_d;
   logic        w_hazard;
   logic        w_pcwrite;
   logic        w_bubble;

   // Only a live instruction can depend on the load sitting in ID/EX.
   assign w_hazard = bus.ID_EX_MemRead
                   && (bus.ID_EX_RegRt != 5'd0)
                   && valid_q
                   && ((bus.ID_EX_RegRt == instr_q[25:21])
                    || (bus.ID_EX_RegRt == instr_q[20:16]));

   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      pc4_d     = pc4_q;
      valid_d   = valid_q;
      cnt_d     = cnt_q;
      w_pcwrite = 1'b1;
      w_bubble  = 1'b0;

      if (Reset) begin
         w_bubble = 1'b1;
         state_d  = ST_RUN;
      end else if (bus.BranchTaken) begin
         instr_d  = 32'h0;
         pc4_d    = 32'h0;
         valid_d  = 1'b0;
         w_bubble = 1'b1;
         state_d  = ST_FLUSH;
      end else begin
         case (state_q)
            ST_RUN, ST_STALL: begin
               if (w_hazard) begin
                  w_pcwrite = 1'b0;
                  w_bubble  = 1'b1;
                  if (cnt_q != C_CNT_MAX) begin
                     cnt_d = cnt_q + 16'd1;
                  end
                  state_d = ST_STALL;
               end else begin
                  instr_d = bus.Instruction;
                  pc4_d   = bus.pc_plus_4;
                  valid_d = 1'b1;
                  state_d = ST_RUN;
               end
            end
            ST_FLUSH: begin
               instr_d = bus.Instruction;
               pc4_d   = bus.pc_plus_4;
               valid_d = 1'b1;
               state_d = ST_RUN;
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q <= ST_RUN;
         instr_q <= 32'h0;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
         cnt_q   <= 16'h0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.Instruction_out = instr_q;
   assign bus.pc_plus_4_out   = pc4_q;
   assign bus.Valid_out       = valid_q;
   assign bus.StallCount      = cnt_q;
   assign bus.PCWrite         = w_pcwrite;
   assign bus.Bubble          = w_bubble;
endmodule
`default_nettype wire

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Clocking: one clock; reset is synchronous and active-high. Ports are named clk and Reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous active-high reset.
REQ-004 Instruction  input  32  fetched instruction from instruction memory.
REQ-005 pc_plus_4  input  32  fetch PC + 4.
REQ-006 ID_EX_MemRead  input  1  MemRead currently held in the ID/EX register.
REQ-007 ID_EX_RegRt  input  5  RegRt currently held in the ID/EX register.
REQ-008 BranchTaken  input  1  resolved taken branch or jump; flush request.
REQ-009 Instruction_out  output  32  registered instruction to decode.
REQ-010 pc_plus_4_out  output  32  registered PC + 4 to decode.
REQ-011 Valid_out  output  1  registered; 1 = Instruction_out is a live instruction.
REQ-012 PCWrite  output  1  combinational; 0 = PC holds this cycle.
REQ-013 Bubble  output  1  combinational; 1 = decode drives all ID/EX control inputs to 0.
REQ-014 StallCount  output  16  registered count of load-use stall cycles.

Function
REQ-015 Hazard is combinational and is asserted when all of the following hold:
  - ID_EX_MemRead = 1;
  - ID_EX_RegRt != 0;
  - Valid_out = 1;
  - ID_EX_RegRt equals Instruction_out[25:21] or Instruction_out[20:16].
REQ-016 The FSM has three states: RUN, STALL and FLUSH. The FSM encoding is internal and is not exported.
REQ-017 RUN with no Hazard and BranchTaken = 0:
  - the register loads Instruction and pc_plus_4;
  - Valid_out goes to 1;
  - PCWrite = 1, Bubble = 0;
  - next state is RUN.
REQ-018 RUN with Hazard and BranchTaken = 0:
  - the register holds its contents;
  - PCWrite = 0, Bubble = 1;
  - StallCount increments;
  - next state is STALL.
REQ-019 STALL repeats the REQ-018 behaviour while Hazard persists, and returns to RUN with a normal load (REQ-017) once Hazard clears.
REQ-020 BranchTaken = 1 in any state has priority over Hazard:
  - the register loads 32'h0 into Instruction_out, 32'h0 into pc_plus_4_out and 0 into Valid_out;
  - PCWrite = 1, Bubble = 1;
  - StallCount is unchanged;
  - next state is FLUSH.
REQ-021 FLUSH with BranchTaken = 0 performs a normal load (REQ-017) of the branch-target instruction, Bubble = 0, and next state is RUN. FLUSH with BranchTaken = 1 repeats REQ-020.
REQ-022 Hazard is never raised in FLUSH, because Valid_out = 0 there.
REQ-023 StallCount saturates at 16'hFFFF and does not wrap.
REQ-024 Latency is one cycle from Instruction to Instruction_out. There is no skid buffering: a stalled fetch is re-presented by the held PC.
REQ-025 All registered outputs change only on a rising edge of clk.

Reset
REQ-026 Reset = 1 on a rising edge sets:
  - state to RUN;
  - Instruction_out = 32'h0 and pc_plus_4_out = 32'h0;
  - Valid_out = 0;
  - StallCount = 0.
REQ-027 Reset has priority over BranchTaken and Hazard. While Reset = 1, PCWrite = 1 and Bubble = 1.
REQ-028 Reset asserted mid-stall or mid-flush abandons that state, and the first cycle after Reset deasserts behaves as RUN.

Verification
REQ-029 Straight-line fetch: after reset, drive Instruction = 32'h8C080004 then 32'h01095020, with ID_EX_MemRead = 0.
  - Expect Instruction_out to follow one cycle later.
  - Expect PCWrite = 1 and Bubble = 0 throughout.
REQ-030 Load-use stall: hold Instruction_out = 32'h01095020 (rs = 8), ID_EX_MemRead = 1, ID_EX_RegRt = 8.
  - Expect PCWrite = 0, Bubble = 1 and the register held.
  - Expect StallCount = 1 after the edge.
  - Drop ID_EX_MemRead: expect a load next edge, with state returning to RUN.
REQ-031 Zero-register exemption: ID_EX_MemRead = 1, ID_EX_RegRt = 0, and an instruction using $0.
  - Expect no stall and StallCount unchanged.
REQ-032 Branch during stall: with the REQ-030 hazard active, assert BranchTaken = 1.
  - Expect Instruction_out = 32'h0, Valid_out = 0 and state FLUSH.
  - Expect StallCount unchanged that cycle.
  - Next cycle, with BranchTaken = 0: expect the target instruction to load and Valid_out = 1.
REQ-033 Saturation and reset: force a sustained hazard for 65540 cycles.
  - Expect StallCount = 16'hFFFF.
  - Then pulse Reset = 1 mid-stall: expect StallCount = 0, Valid_out = 0 and state RUN.
